// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   WORD           width of byte addresses
//   INSTR_LEN      width of one instruction
//   loader_state_e loader FSM state encodings
package instr_mem_loader_pkg;

  localparam int unsigned WORD      = 32;
  localparam int unsigned INSTR_LEN = 32;

  typedef enum logic [2:0] {
    LoaderLen   = 3'd0,
    LoaderData  = 3'd1,
    LoaderWrite = 3'd2,
    LoaderDone  = 3'd3,
    LoaderError = 3'd4
  } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// Collects four little-endian bytes into one 32-bit word.
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   clear    in   drop any partially collected bytes
//   load     in   data is accepted this cycle
//   data     in   incoming byte
//   word     out  assembled word, valid while complete is high
//   complete out  the byte accepted this cycle is the 4th of a word
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        complete
);

  // Only the three earlier bytes need storing; the 4th is taken straight from the input so the
  // word is available in the same cycle it completes.
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= {data, shift_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  always_comb begin
    complete = load && (cnt_q == 2'd3);
    word     = {data, shift_q};
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from a little-endian byte stream into instruction memory. The stream is a
// 4-byte instruction count N followed by N 4-byte instructions; the CPU is held in reset
// until all N instructions have been written.
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   start        in   re-arm pulse, honoured in DONE or ERROR only
//   in_data      in   stream byte
//   in_valid     in   in_data is valid
//   in_ready     out  loader accepts in_data this cycle
//   wr_en        out  one-cycle instruction-memory write strobe
//   wr_addr      out  byte address of the write
//   wr_data      out  assembled instruction
//   cpu_hold     out  keep the processor in reset
//   done         out  image loaded successfully
//   error        out  count exceeded MAX_INSTR
//   instr_count  out  instruction count from the header
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned     MAX_INSTR = 256,
  parameter logic [WORD-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [WORD-1:0]      wr_addr,
  output logic [INSTR_LEN-1:0] wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          instr_count
);

  loader_state_e state_q, state_d;

  logic [31:0]          idx_q;
  logic [WORD-1:0]      addr_q;
  logic [INSTR_LEN-1:0] data_q;
  logic [31:0]          count_q;

  logic        accept;
  logic        asm_load;
  logic        asm_complete;
  logic [31:0] asm_word;
  logic        rearm;

  assign accept   = in_valid && in_ready;
  // Bytes taken in ERROR are only drained, never assembled.
  assign asm_load = accept && ((state_q == LoaderLen) || (state_q == LoaderData));
  assign rearm    = start && ((state_q == LoaderDone) || (state_q == LoaderError));

  byte_assembler u_byte_assembler (
    .clk      (clk),
    .reset    (reset),
    .clear    (rearm),
    .load     (asm_load),
    .data     (in_data),
    .word     (asm_word),
    .complete (asm_complete)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LoaderLen;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LoaderLen: begin
        if (asm_complete) begin
          if (asm_word > MAX_INSTR) begin
            state_d = LoaderError;
          end else if (asm_word == 32'd0) begin
            state_d = LoaderDone;
          end else begin
            state_d = LoaderData;
          end
        end
      end
      LoaderData: begin
        if (asm_complete) state_d = LoaderWrite;
      end
      LoaderWrite: begin
        state_d = (32'(idx_q + 32'd1) == count_q) ? LoaderDone : LoaderData;
      end
      LoaderDone, LoaderError: begin
        if (start) state_d = LoaderLen;
      end
      default: state_d = LoaderLen;
    endcase
  end

  // Datapath: header count, instruction word, index and write address.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      count_q <= '0;
    end else if (rearm) begin
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
    end else begin
      if ((state_q == LoaderLen) && asm_complete) count_q <= asm_word;
      if ((state_q == LoaderData) && asm_complete) data_q <= asm_word;
      if (state_q == LoaderWrite) begin
        idx_q  <= idx_q + 32'd1;
        addr_q <= addr_q + WORD'(4);
      end
    end
  end

  // Outputs.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      LoaderLen:   in_ready = 1'b1;
      LoaderData:  in_ready = 1'b1;
      LoaderWrite: wr_en    = 1'b1;
      LoaderDone: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      LoaderError: begin
        in_ready = 1'b1;
        error    = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign instr_count = count_q;

endmodule
